// File: rtl/lcd_text_driver.sv
// HD44780 character-LCD controller: ROWS x COLS text buffer written by the CPU,
// power-up wait, init command sequence, then continuous refresh of the panel.
// All panel timing comes from cycle counters; the busy flag is never read.
module lcd_text_driver #(
    parameter int   COLS          = 16,
    parameter int   ROWS          = 2,
    parameter int   T_POWERUP_CYC = 750000,
    parameter int   T_EN_CYC      = 25,
    parameter int   T_CMD_CYC     = 2500,
    parameter int   T_CLR_CYC     = 100000,
    parameter logic BACKLIGHT     = 1'b1,
    localparam int  NCELLS        = ROWS * COLS,
    localparam int  AW            = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          clear,
    output logic          ready,
    output logic          frame_done,
    output logic [7:0]    LCD_DATA,
    output logic          LCD_RS,
    output logic          LCD_RW,
    output logic          LCD_EN,
    output logic          LCD_ON,
    output logic          LCD_BLON
);
    localparam int CW    = $clog2(COLS + 1);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int T_A   = (T_POWERUP_CYC > T_CLR_CYC) ? T_POWERUP_CYC : T_CLR_CYC;
    localparam int T_B   = (T_CMD_CYC > T_EN_CYC) ? T_CMD_CYC : T_EN_CYC;
    localparam int T_AB  = (T_A > T_B) ? T_A : T_B;
    localparam int T_MAX = (T_AB > 2) ? T_AB : 2;
    localparam int TW    = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {
        ST_POWERUP = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // DDRAM start address of each panel row
    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'h14;
            default: row_base = 8'h54;
        endcase
    endfunction

    // 8-bit bus, 2 lines, display on, clear, entry mode increment
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    state_t          state_r, state_s;
    logic [TW-1:0]   cnt_r, cnt_s, limit_s;
    logic            cnt_last_s, enter_setup_s, hold_end_s, is_clr_s;
    logic            init_phase_r;
    logic [1:0]      init_idx_r;
    logic [RW-1:0]   row_r;
    logic [CW-1:0]   col_r;
    logic [AW-1:0]   rd_addr_r;
    logic            sel_rs_s, sel_last_s;
    logic [7:0]      sel_data_s;
    logic [7:0]      data_r;
    logic            rs_r, last_r, en_r, en_s, on_r, ready_r, frame_done_r, frame_done_s;
    logic [7:0]      buffer [NCELLS];
    logic [AW-1:0]   sweep_idx_r;
    logic            buf_we_s;
    logic [AW-1:0]   buf_waddr_s;
    logic [7:0]      buf_wdata_s;

    assign is_clr_s = (rs_r == 1'b0) && (data_r == 8'h01);

    // State and phase-timer register
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_r <= ST_POWERUP;
            cnt_r   <= {TW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state: each phase lasts a fixed number of cycles, then advances
    always_comb begin
        case (state_r)
            ST_POWERUP: limit_s = TW'(T_POWERUP_CYC);
            ST_SETUP:   limit_s = TW'(2);
            ST_STROBE:  limit_s = TW'(T_EN_CYC);
            ST_HOLD:    limit_s = is_clr_s ? TW'(T_CLR_CYC) : TW'(T_CMD_CYC);
            default:    limit_s = TW'(1);
        endcase
        cnt_last_s = (cnt_r == (limit_s - TW'(1)));
        state_s    = state_r;
        if (cnt_last_s) begin
            cnt_s = {TW{1'b0}};
            case (state_r)
                ST_POWERUP: state_s = ST_SETUP;
                ST_SETUP:   state_s = ST_STROBE;
                ST_STROBE:  state_s = ST_HOLD;
                ST_HOLD:    state_s = ST_SETUP;
                default:    state_s = ST_POWERUP;
            endcase
        end else begin
            cnt_s = cnt_r + TW'(1);
        end
        enter_setup_s = cnt_last_s && ((state_r == ST_POWERUP) || (state_r == ST_HOLD));
        hold_end_s    = cnt_last_s && (state_r == ST_HOLD);
    end

    // Pick the next byte to send from the init table or the refresh position
    always_comb begin
        sel_rs_s   = 1'b0;
        sel_last_s = 1'b0;
        if (init_phase_r) begin
            sel_data_s = init_cmd(init_idx_r);
        end else if (col_r == {CW{1'b0}}) begin
            sel_data_s = 8'h80 | row_base(2'(row_r));
        end else begin
            sel_rs_s   = 1'b1;
            sel_data_s = buffer[rd_addr_r];
            sel_last_s = (col_r == CW'(COLS)) && (row_r == RW'(ROWS - 1));
        end
    end

    // Latch the byte at SETUP entry (held on the bus until HOLD ends) and step the pointer
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            init_phase_r <= 1'b1;
            init_idx_r   <= 2'd0;
            row_r        <= {RW{1'b0}};
            col_r        <= {CW{1'b0}};
            rd_addr_r    <= {AW{1'b0}};
            data_r       <= 8'h00;
            rs_r         <= 1'b0;
            last_r       <= 1'b0;
        end else if (enter_setup_s) begin
            data_r <= sel_data_s;
            rs_r   <= sel_rs_s;
            last_r <= sel_last_s;
            if (init_phase_r) begin
                if (init_idx_r == 2'd3) begin
                    init_phase_r <= 1'b0;
                    row_r        <= {RW{1'b0}};
                    col_r        <= {CW{1'b0}};
                end else begin
                    init_idx_r <= init_idx_r + 2'd1;
                end
            end else if (col_r == CW'(COLS)) begin
                col_r     <= {CW{1'b0}};
                row_r     <= (row_r == RW'(ROWS - 1)) ? {RW{1'b0}} : row_r + RW'(1);
                rd_addr_r <= sel_last_s ? {AW{1'b0}} : rd_addr_r + AW'(1);
            end else begin
                col_r <= col_r + CW'(1);
                if (col_r != {CW{1'b0}}) begin
                    rd_addr_r <= rd_addr_r + AW'(1);
                end
            end
        end
    end

    // Output decode from the upcoming state
    always_comb begin
        en_s         = (state_s == ST_STROBE);
        frame_done_s = hold_end_s && last_r;
    end

    // Registered panel strobe, power and frame pulse
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            en_r         <= 1'b0;
            on_r         <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            en_r         <= en_s;
            on_r         <= 1'b1;
            frame_done_r <= frame_done_s;
        end
    end

    // Buffer write port: the sweep has priority, then clear blocks writes, then CPU writes
    always_comb begin
        buf_we_s    = 1'b0;
        buf_waddr_s = wr_addr;
        buf_wdata_s = wr_data;
        if (!ready_r) begin
            buf_we_s    = 1'b1;
            buf_waddr_s = sweep_idx_r;
            buf_wdata_s = 8'h20;
        end else if (clear) begin
            buf_we_s = 1'b0;
        end else if (wr_en && ({1'b0, wr_addr} < (AW + 1)'(NCELLS))) begin
            buf_we_s = 1'b1;
        end else begin
            buf_we_s = 1'b0;
        end
    end

    // Text buffer storage
    always_ff @(posedge CLOCK_50) begin
        if (buf_we_s) begin
            buffer[buf_waddr_s] <= buf_wdata_s;
        end
    end

    // Fill sweep: runs after reset and after each accepted clear, one cell per cycle
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            ready_r     <= 1'b0;
            sweep_idx_r <= {AW{1'b0}};
        end else if (!ready_r) begin
            if (sweep_idx_r == AW'(NCELLS - 1)) begin
                ready_r     <= 1'b1;
                sweep_idx_r <= {AW{1'b0}};
            end else begin
                sweep_idx_r <= sweep_idx_r + AW'(1);
            end
        end else if (clear) begin
            ready_r     <= 1'b0;
            sweep_idx_r <= {AW{1'b0}};
        end
    end

    assign ready      = ready_r;
    assign frame_done = frame_done_r;
    assign LCD_DATA   = data_r;
    assign LCD_RS     = rs_r;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = en_r;
    assign LCD_ON     = on_r;
    assign LCD_BLON   = BACKLIGHT;
endmodule
